// File: rtl/tdpr_bram_param_if.sv
// One port of the true dual-port RAM: the access request and the read response.
// The RAM top takes two of these, one for port A and one for port B.
interface tdpr_bram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  modport master (output en, we, addr, din, input  dout, dout_valid);
  modport slave  (input  en, we, addr, din, output dout, dout_valid);
endinterface

// File: rtl/tdpr_bram_param.sv
// Inferred true dual-port RAM with per-port write modes, 1- or 2-cycle read latency and read-valid flags.
// Optional `TDPR_COLLISION_FLAG_EN adds the collision / collision_ww outputs.

module tdpr_port_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:1]               vld_q;
  logic [STAGES:1][DATA_W-1:0]   dat_q;

  assign vld_pipe = {vld_q, rd};

  // Stage 1 only loads on an access that updates dout; later stages just follow it,
  // so a held value stays held at every latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (ld) dat_q[1] <= ld_data;
      for (int s = 2; s <= STAGES; s++) dat_q[s] <= dat_q[s-1];
    end
  end

  assign dout       = dat_q[STAGES];
  assign dout_valid = vld_pipe[STAGES];
endmodule

module tdpr_bram_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int WMODE_A = 0,
  parameter int WMODE_B = 0,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  tdpr_bram_param_if.slave port_a,
  tdpr_bram_param_if.slave port_b
`ifdef TDPR_COLLISION_FLAG_EN
  ,
  output logic             collision,
  output logic             collision_ww
`endif
);
  localparam int NUM_PORTS = 2;
  localparam int STAGES    = (OUT_REG != 0) ? 2 : 1;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $fatal(1, "tdpr_bram_param: DEPTH=%0d does not fit ADDR_W=%0d", DEPTH, ADDR_W);
  end
  if (WMODE_A < 0 || WMODE_A > 2 || WMODE_B < 0 || WMODE_B > 2) begin : g_bad_wmode
    $fatal(1, "tdpr_bram_param: WMODE_A=%0d WMODE_B=%0d, legal range 0..2", WMODE_A, WMODE_B);
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $fatal(1, "tdpr_bram_param: DATA_W=%0d, legal range 1..64", DATA_W);
  end

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } req_t;

  req_t [NUM_PORTS-1:0]              req;
  logic [NUM_PORTS-1:0]              in_rng;
  logic [NUM_PORTS-1:0]              wr;
  logic                              same_addr;
  logic                              wr_b;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  dout;
  logic [NUM_PORTS-1:0]              dout_valid;

  // Declaration initialiser gives the all-zero power-up image; the array itself is never reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign req[0] = '{port_a.en, port_a.we, port_a.addr, port_a.din};
  assign req[1] = '{port_b.en, port_b.we, port_b.addr, port_b.din};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    assign in_rng[p] = {1'b0, req[p].addr} < DEPTH_L;
    assign wr[p]     = req[p].en & req[p].we & in_rng[p];
  end

  // Write/write to one address: port A wins, port B's write is dropped.
  assign same_addr = req[0].addr == req[1].addr;
  assign wr_b      = wr[1] & ~(wr[0] & same_addr);

  always_ff @(posedge clk) begin
    if (wr[0]) mem[req[0].addr[IDX_W-1:0]] <= req[0].din;
    if (wr_b)  mem[req[1].addr[IDX_W-1:0]] <= req[1].din;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int MODE = (p == 0) ? WMODE_A : WMODE_B;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ld_data;
    logic              ld;
    logic              rd;

    // rd_word is the pre-edge array word, so a reader colliding with a writer sees old data.
    always_comb begin
      rd_word = in_rng[p] ? mem[req[p].addr[IDX_W-1:0]] : '0;
      rd      = req[p].en & ~req[p].we;
      ld      = rd;
      ld_data = rd_word;
      if (req[p].en && req[p].we) begin
        if (MODE == 0)      ld = 1'b1;
        else if (MODE == 1) begin
          ld      = 1'b1;
          ld_data = req[p].din;
        end
      end
    end

    tdpr_port_pipe #(.DATA_W(DATA_W), .STAGES(STAGES)) u_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld         (ld),
      .ld_data    (ld_data),
      .rd         (rd),
      .dout       (dout[p]),
      .dout_valid (dout_valid[p])
    );
  end

  assign port_a.dout       = dout[0];
  assign port_a.dout_valid = dout_valid[0];
  assign port_b.dout       = dout[1];
  assign port_b.dout_valid = dout_valid[1];

`ifdef TDPR_COLLISION_FLAG_EN
  logic                col_hit;
  logic                col_ww_hit;
  logic [STAGES:0]     col_pipe;
  logic [STAGES:0]     ww_pipe;
  logic [STAGES:1]     col_q;
  logic [STAGES:1]     ww_q;

  assign col_hit    = req[0].en & req[1].en & in_rng[0] & same_addr & (req[0].we | req[1].we);
  assign col_ww_hit = col_hit & req[0].we & req[1].we;
  assign col_pipe   = {col_q, col_hit};
  assign ww_pipe    = {ww_q, col_ww_hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      ww_q  <= '0;
    end else begin
      col_q <= col_pipe[STAGES-1:0];
      ww_q  <= ww_pipe[STAGES-1:0];
    end
  end

  assign collision    = col_pipe[STAGES];
  assign collision_ww = ww_pipe[STAGES];
`endif
endmodule

// File: doc/tdpr_bram_param.md
Name: tdpr_bram_param

Overview:
- Parametrised true dual-port block RAM, inferred from RTL; no vendor IP core.
- Two independent read/write ports share one clock and one storage array.
- Adds four things: per-port write modes, a configurable read latency, read-valid flags, and deterministic same-address collision rules.
- Sits where the fixed 8x256 dual-port memory sat: a drop-in successor for packet buffers and scratchpads.

Parameters:
- DATA_W, 8, data width in bits per word (1..64).
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must be <= 2**ADDR_W.
- WMODE_A, 0, port A write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- WMODE_B, 0, port B write mode; same encoding as WMODE_A.
- OUT_REG, 0, 1 adds an output pipeline register on both ports.

Ports:
- clk  in  1  single clock for both ports; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write enable (1 write, 0 read); qualified by en_a.
- addr_a  in  ADDR_W  port A word address.
- din_a  in  DATA_W  port A write data.
- dout_a  out  DATA_W  port A read data.
- dout_valid_a  out  1  pulses for one cycle when dout_a carries data from a port A read.
- en_b, we_b, addr_b, din_b, dout_b, dout_valid_b: port B equivalents of the port A signals.

Behaviour:
- Reset: rst_n low asynchronously clears dout_a, dout_b, dout_valid_a, dout_valid_b and all pipeline stages to 0.
- Array contents are not reset; the array is initialised to all-zero at time 0 for simulation and bitstream.
- Access: an access occurs when en_x=1 at a rising edge. Read is we_x=0; write is we_x=1. With en_x=0 the port does nothing and dout_x holds its value.
- Latency: read data and dout_valid_x appear 1 cycle after the access edge if OUT_REG=0, 2 cycles if OUT_REG=1.
- Pipelining: back-to-back reads give one result per cycle, with no bubbles.
- dout_valid_x is asserted only for reads.
- Write port dout_x, per write mode:
  - READ_FIRST: dout_x takes the old array word.
  - WRITE_FIRST: dout_x takes din_x.
  - NO_CHANGE: dout_x holds its value.
  - In all modes dout_valid_x stays 0 for the write and the update follows the same latency.
- Out of range (addr >= DEPTH): writes are ignored; reads return 0 with dout_valid asserted.
- Collisions (same in-range address, same edge):
  - A write + B write: port A data is stored and port B's write is dropped.
  - One port writes, the other reads: the reader returns the old word, independent of write mode.
  - Both read: both return the same word.
- Reset mid-operation: in-flight pipeline results are discarded and no valid pulse is emitted after rst_n rises. A write sampled on the same edge that rst_n deasserts is performed normally.
- Elaboration: DEPTH > 2**ADDR_W or WMODE > 2 is a fatal error.

Optional Feature:
- Macro: TDPR_COLLISION_FLAG_EN.
- Defined:
  - Adds output port collision (1 bit), pulsed for one cycle, aligned with read latency, on any same-address collision involving at least one write.
  - Adds output port collision_ww (1 bit), set when the collision was write/write (port B write dropped).
  - Both ports reset to 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with reads in flight -> all dout/valid read 0 immediately; no valid pulse after release.
- Basic read: A writes 0x5A to addr 0x10, then B reads 0x10 with OUT_REG=0 -> dout_b=0x5A and dout_valid_b=1 exactly 1 cycle later. With OUT_REG=1 the same result arrives 2 cycles later.
- Write modes: addr 3 holds 0x11, A writes 0x22 to addr 3. WMODE_A=0 gives dout_a=0x11; WMODE_A=1 gives 0x22; WMODE_A=2 keeps the prior dout_a. dout_valid_a=0 in all cases.
- Write/write collision: A writes 0xAA and B writes 0xBB to addr 7 on the same edge -> subsequent read of 7 returns 0xAA. With TDPR_COLLISION_FLAG_EN, collision=1 and collision_ww=1 for one cycle.
- Read/write collision: addr 9 holds 0x01; A writes 0x02 while B reads 9 -> dout_b=0x01, and the next B read of 9 returns 0x02.
- Streaming and range: 256 back-to-back A reads of addresses 0..255 after a pattern fill -> 256 consecutive valid pulses with matching data. With DEPTH=200, a write to addr 210 is ignored and a read of it returns 0 with valid=1.
